// File: rtl/class_hvec_search.sv
// Class-hypervector search: buffers one query hypervector, sweeps every class ROM
// address and returns the class with the highest Hamming similarity.
module class_hvec_search #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int N_CLASSES          = 8,
    parameter int N_FRAMES           = 3,
    parameter int CID_W              = $clog2(N_CLASSES),
    parameter int FIX_W              = $clog2(N_FRAMES),
    parameter int SCORE_W            = $clog2(N_FRAMES*DI_PARALLEL_W_BITS+1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          q_valid,
    output logic                          q_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] q_frame,
    output logic [CID_W-1:0]              frame_id,
    output logic [FIX_W-1:0]              frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CID_W-1:0]              res_class,
    output logic [SCORE_W-1:0]            res_score,
    output logic                          busy
);

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    localparam logic [FIX_W-1:0] LAST_FIX = FIX_W'(N_FRAMES-1);
    localparam logic [CID_W-1:0] LAST_CID = CID_W'(N_CLASSES-1);

    state_t state, state_nxt;

    logic [DI_PARALLEL_W_BITS-1:0] qbuf [N_FRAMES];
    logic [DI_PARALLEL_W_BITS-1:0] match_vec;
    logic [FIX_W-1:0]              load_idx;
    logic [SCORE_W-1:0]            acc, best_score, sim, total, cand_score;
    logic [CID_W-1:0]              best_class, cand_class;
    logic                          q_accept, last_frame, last_class, take;

    // Similarity of the current address: popcount of matching bits.
    always_comb begin
        match_vec = ~(class_vec_in ^ qbuf[frame_index]);
        sim = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            sim = sim + SCORE_W'(match_vec[i]);
        end
    end

    assign total      = acc + sim;
    assign last_frame = (frame_index == LAST_FIX);
    assign last_class = (frame_id == LAST_CID);
    // Strict compare keeps the lowest index on ties; class 0 always seeds the best.
    assign take       = (total > best_score) || (frame_id == '0);
    assign cand_score = take ? total : best_score;
    assign cand_class = take ? frame_id : best_class;
    assign q_accept   = q_valid && q_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                q_ready = 1'b1;
                if (q_valid && load_idx == LAST_FIX) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last_frame && last_class) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // The query buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (q_accept) begin
            qbuf[load_idx] <= q_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx    <= '0;
            frame_id    <= '0;
            frame_index <= '0;
            acc         <= '0;
            best_score  <= '0;
            best_class  <= '0;
            res_class   <= '0;
            res_score   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (q_accept) begin
                        if (load_idx == LAST_FIX) begin
                            load_idx    <= '0;
                            frame_id    <= '0;
                            frame_index <= '0;
                            acc         <= '0;
                            best_score  <= '0;
                            best_class  <= '0;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!last_frame) begin
                        acc         <= total;
                        frame_index <= frame_index + 1'b1;
                    end else begin
                        acc         <= '0;
                        frame_index <= '0;
                        best_score  <= cand_score;
                        best_class  <= cand_class;
                        if (!last_class) begin
                            frame_id <= frame_id + 1'b1;
                        end else begin
                            frame_id  <= '0;
                            res_class <= cand_class;
                            res_score <= cand_score;
                        end
                    end
                end
                DONE: begin
                    frame_id    <= '0;
                    frame_index <= '0;
                end
                default: begin
                    frame_id    <= '0;
                    frame_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_class_hvec_search.sv
// Randomized bench for class_hvec_search with a behavioural class ROM and an
// argmax reference model computed directly from Hamming similarities.
module tb_class_hvec_search;

    localparam int W   = 64;
    localparam int NC  = 8;
    localparam int NF  = 3;
    localparam int CW  = $clog2(NC);
    localparam int FW  = $clog2(NF);
    localparam int SW  = $clog2(NF*W+1);
    localparam int SCANLEN = NC*NF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          q_valid;
    logic          q_ready;
    logic [W-1:0]  q_frame;
    logic [CW-1:0] frame_id;
    logic [FW-1:0] frame_index;
    logic [W-1:0]  class_vec_in;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_class;
    logic [SW-1:0] res_score;
    logic          busy;

    logic [W-1:0] rom [NC][NF];
    logic [W-1:0] qry [NF];

    int total = 0;
    int bad   = 0;
    int expClass, expScore;

    class_hvec_search #(
        .DI_PARALLEL_W_BITS(W), .N_CLASSES(NC), .N_FRAMES(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .q_valid(q_valid), .q_ready(q_ready), .q_frame(q_frame),
        .frame_id(frame_id), .frame_index(frame_index),
        .class_vec_in(class_vec_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: combinational lookup of the addressed class frame.
    always_comb begin
        class_vec_in = '0;
        if (int'(frame_id) < NC && int'(frame_index) < NF) begin
            class_vec_in = rom[frame_id][frame_index];
        end
    end

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Argmax of summed per-frame matching-bit counts; first maximum wins.
    task automatic refModel();
        int best;
        best = -1;
        expClass = 0;
        for (int c = 0; c < NC; c++) begin
            int s;
            s = 0;
            for (int f = 0; f < NF; f++) begin
                s += $countones(~(rom[c][f] ^ qry[f]));
            end
            if (s > best) begin
                best = s;
                expClass = c;
            end
        end
        expScore = best;
    endtask

    task automatic randomRom();
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                rom[c][f] = rnd64();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_q_ready"}, q_ready, 1);
        checkOutput({tag, "_frame_id"}, frame_id, 0);
        checkOutput({tag, "_frame_index"}, frame_index, 0);
    endtask

    // Loads qry with gap idle cycles before each frame, follows the scan address by
    // address, holds the result for hold cycles and completes the handshake.
    // abortAt >= 0 pulses reset asynchronously at that scan cycle instead.
    task automatic applyStimulus(input int gap, input int hold, input int abortAt);
        refModel();
        for (int f = 0; f < NF; f++) begin
            for (int g = 0; g < gap; g++) begin
                q_valid = 1'b0;
                q_frame = rnd64();
                tick();
                checkOutput("q_ready_gap", q_ready, 1);
            end
            q_valid = 1'b1;
            q_frame = qry[f];
            checkOutput("q_ready_load", q_ready, 1);
            tick();
        end
        for (int k = 0; k < SCANLEN; k++) begin
            checkOutput("scan_res_valid", res_valid, 0);
            checkOutput("scan_q_ready", q_ready, 0);
            checkOutput("scan_busy", busy, 1);
            checkOutput("scan_frame_id", frame_id, k / NF);
            checkOutput("scan_frame_index", frame_index, k % NF);
            if (k == abortAt) begin
                #2 rst_n = 1'b0;
                #1;
                checkIdle("async_rst");
                checkOutput("async_rst_res_class", res_class, 0);
                checkOutput("async_rst_res_score", res_score, 0);
                tick();
                rst_n = 1'b1;
                q_valid = 1'b0;
                res_ready = 1'b0;
                return;
            end
            q_valid   = 1'b1;
            q_frame   = rnd64();
            res_ready = 1'($urandom);
            tick();
        end
        q_valid   = 1'b0;
        res_ready = 1'b0;
        checkOutput("done_res_valid", res_valid, 1);
        checkOutput("done_res_class", res_class, expClass);
        checkOutput("done_res_score", res_score, expScore);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_q_ready", q_ready, 0);
        for (int h = 0; h < hold; h++) begin
            q_valid = 1'b1;
            q_frame = rnd64();
            tick();
            checkOutput("hold_res_valid", res_valid, 1);
            checkOutput("hold_res_class", res_class, expClass);
            checkOutput("hold_res_score", res_score, expScore);
            checkOutput("hold_q_ready", q_ready, 0);
        end
        q_valid   = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkIdle("after_handshake");
    endtask

    initial begin
        rst_n     = 1'b0;
        q_valid   = 1'b0;
        q_frame   = '0;
        res_ready = 1'b0;
        randomRom();
        #2;
        checkIdle("reset");
        checkOutput("reset_res_class", res_class, 0);
        checkOutput("reset_res_score", res_score, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random ROM and query.
        for (int f = 0; f < NF; f++) qry[f] = rnd64();
        applyStimulus(0, 0, -1);

        // Exact match duplicated at a higher class index: lowest index wins.
        randomRom();
        for (int f = 0; f < NF; f++) begin
            rom[6][f] = rom[2][f];
            qry[f]    = rom[2][f];
        end
        applyStimulus(0, 1, -1);

        // All-zero query against an all-zero class 0, with gaps and a long hold.
        randomRom();
        for (int f = 0; f < NF; f++) begin
            rom[0][f] = '0;
            qry[f]    = '0;
        end
        applyStimulus(3, 10, -1);

        // Every class scores zero: class 0 must still be reported.
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                rom[c][f] = '1;
        for (int f = 0; f < NF; f++) qry[f] = '0;
        applyStimulus(1, 2, -1);

        // Reset mid-scan, then a full query must complete normally.
        randomRom();
        for (int f = 0; f < NF; f++) qry[f] = rnd64();
        applyStimulus(0, 0, 10);
        tick();
        for (int f = 0; f < NF; f++) qry[f] = rnd64();
        applyStimulus(0, 1, -1);

        for (int it = 0; it < 6; it++) begin
            randomRom();
            for (int f = 0; f < NF; f++) qry[f] = rnd64();
            if (it % 2 == 1) begin
                for (int f = 0; f < NF; f++) qry[f] = rom[$urandom_range(NC-1)][f] ^ W'(64'h1 << $urandom_range(W-1));
            end
            applyStimulus(int'($urandom_range(3)), int'($urandom_range(4)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/class_hvec_search.md
Name: class_hvec_search

Overview:
- Reader side of the class-hypervector ROM interface. Buffers one query hypervector, delivered as N_FRAMES frames of DI_PARALLEL_W_BITS bits.
- Sweeps every (frame_id, frame_index) address of class_hvec_gen, accumulates Hamming similarity (popcount of XNOR) per class, and returns the argmax class with its score over a valid/ready result port.
- Sits between the encoder output stream and the classification result sink in inference mode.

Parameters:
- DI_PARALLEL_W_BITS, 64, frame width in bits; must match class_hvec_gen.
- N_CLASSES, 8, number of classes; frame_id range 0..N_CLASSES-1.
- N_FRAMES, 3, frames per hypervector; frame_index range 0..N_FRAMES-1.
- CID_W, $clog2(N_CLASSES), width of the class index.
- FIX_W, $clog2(N_FRAMES), width of the frame index.
- SCORE_W, $clog2(N_FRAMES*DI_PARALLEL_W_BITS+1), width of the similarity score.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q_valid  in  1  query frame valid.
- q_ready  out  1  query frame accepted when q_valid && q_ready.
- q_frame  in  DI_PARALLEL_W_BITS  query frame; frames arrive in order index 0..N_FRAMES-1.
- frame_id  out  CID_W  class address to class_hvec_gen.
- frame_index  out  FIX_W  frame address to class_hvec_gen.
- class_vec_in  in  DI_PARALLEL_W_BITS  class_vec_out from class_hvec_gen; combinational function of frame_id/frame_index.
- res_valid  out  1  result valid.
- res_ready  in  1  result sink ready.
- res_class  out  CID_W  argmax class.
- res_score  out  SCORE_W  similarity of res_class.
- busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset: clk and rst_n; reset is asynchronous and active-low. Reset forces state=LOAD, load_idx=0, frame_id=0, frame_index=0, acc=0, best_score=0, best_class=0, res_valid=0, res_class=0, res_score=0, busy=0. The query buffer is not cleared. Reset at any point discards partial loads and scans with no output.

LOAD:
- q_ready=1.
- On each accepted frame: qbuf[load_idx] <= q_frame and load_idx increments.
- On acceptance with load_idx==N_FRAMES-1: load_idx <= 0, state <= SCAN, frame_id <= 0, frame_index <= 0, acc <= 0, best_score <= 0, best_class <= 0.
- frame_id and frame_index are held at 0 throughout LOAD.

SCAN:
- q_ready=0. Each cycle computes sim = popcount(~(class_vec_in ^ qbuf[frame_index])), sampled at the clock edge.
- If frame_index < N_FRAMES-1: acc <= acc+sim and frame_index increments.
- If frame_index == N_FRAMES-1: total = acc+sim. When total > best_score (strict), or when frame_id==0, then best_score <= total and best_class <= frame_id. Then acc <= 0 and frame_index <= 0.
- If frame_id < N_CLASSES-1, frame_id increments. Otherwise state <= DONE, and res_class/res_score load the final best, including the last class's compare.
- Ties keep the lowest class index.
- Address order: (0,0),(0,1)..(0,N_FRAMES-1),(1,0)...; exactly one address per cycle.
- SCAN lasts N_CLASSES*N_FRAMES cycles. res_valid rises N_CLASSES*N_FRAMES edges after the edge that accepts the last query frame (24 at defaults).
- The accumulator never overflows, because SCORE_W covers the maximum N_FRAMES*DI_PARALLEL_W_BITS.

DONE:
- res_valid=1, q_ready=0. res_class and res_score are held stable until the handshake.
- On res_valid && res_ready: res_valid <= 0, state <= LOAD. q_ready is high the following cycle; there is no same-cycle accept.
- frame_id and frame_index return to 0.
- q_valid is ignored outside LOAD and has no side effects.

Test Plan:
Config for scenarios 1–5: DI_PARALLEL_W_BITS=8, N_CLASSES=4, N_FRAMES=2, with a behavioural ROM (class c, frame f) = {c,f} patterns.
1. ROM class0=00/00, class1=0F/0F, class2=A5/3C, class3=FF/FF; query A5,3C -> res_class=2, res_score=16; class3 score=8, below 16.
2. Query FF,FF with ROM class1 == class3 == FF/FF -> res_class=1, res_score=16 (tie keeps lowest index).
3. Query 00,00 against the ROM of scenario 1 -> res_class=0, res_score=16; address trace (0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1); res_valid exactly 8 edges after the last q accept.
4. Query frames with q_valid gaps of 3 idle cycles -> same result as scenario 1; frames stored in arrival order; q_ready=0 throughout SCAN.
5. res_ready held low 10 cycles in DONE -> res_valid, res_class, res_score stable; q_ready=0. Raising res_ready gives res_valid=0 and q_ready=1 on the next cycle.
6. rst_n pulsed low mid-SCAN (default config with class_hvec_gen attached) -> all outputs reach reset values immediately, asynchronously. A subsequent full query completes in 24 SCAN cycles with the correct argmax.
